// File: rtl/alu_sequencer_if.sv
// Datapath bus between the sequencer and the 8-bit ALU/register datapath.
// master (sequencer) drives wr, a, b, opcode; slave (datapath) returns y
// one cycle after wr.
interface alu_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  wr;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] opcode;
    logic [DATA_WIDTH-1:0] y;

    modport master (output wr, a, b, opcode, input  y);
    modport slave  (input  wr, a, b, opcode, output y);
endinterface

// File: rtl/alu_sequencer.sv
// Program-driven controller for the ALU datapath: runs a stored program,
// issuing one instruction every 3 cycles and writing each result back into
// the accumulator until a halt opcode or the last store entry.
// Ports: clk/reset (sync, active-high); prog_we_i/prog_addr_i/prog_data_i load
// the store in IDLE; start_i/acc_init_i launch a run; busy_o/done_o/pc_o/acc_o
// report status; dp (master) carries wr/a/b/opcode out and y back.
module alu_sequencer #(
    parameter int                     DATA_WIDTH = 8,
    parameter int                     ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0]  HALT_OP    = DATA_WIDTH'(8'hFF)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    prog_we_i,
    input  logic [ADDR_WIDTH-1:0]   prog_addr_i,
    input  logic [2*DATA_WIDTH-1:0] prog_data_i,
    input  logic                    start_i,
    input  logic [DATA_WIDTH-1:0]   acc_init_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [ADDR_WIDTH-1:0]   pc_o,
    output logic [DATA_WIDTH-1:0]   acc_o,
    alu_sequencer_if.master         dp
);
    localparam int                    DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PC = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WB
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   acc_q, acc_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [DATA_WIDTH-1:0]   op_q, op_d;
    logic                    done_q, done_d;

    // Instruction store: deliberately outside the reset so a program survives
    // an aborted run.
    logic [2*DATA_WIDTH-1:0] store_q [DEPTH];

    logic [2*DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0]   instr_op;
    logic [DATA_WIDTH-1:0]   instr_imm;

    assign instr     = store_q[pc_q];
    assign instr_op  = instr[2*DATA_WIDTH-1:DATA_WIDTH];
    assign instr_imm = instr[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!reset && state_q == S_IDLE && prog_we_i) begin
            store_q[prog_addr_i] <= prog_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    pc_d    = '0;
                    acc_d   = acc_init_i;
                    done_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (instr_op == HALT_OP) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    a_d     = acc_q;
                    b_d     = instr_imm;
                    op_d    = instr_op;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WB;
            end
            S_WB: begin
                acc_d = dp.y;
                // The last store entry ends the run; pc never wraps to 0.
                if (pc_q == LAST_PC) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            done_q  <= done_d;
        end
    end

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = done_q;
    assign pc_o      = pc_q;
    assign acc_o     = acc_q;
    assign dp.wr     = (state_q == S_ISSUE);
    assign dp.a      = a_q;
    assign dp.b      = b_q;
    assign dp.opcode = op_q;
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Program-driven controller for the 8-bit ALU/register datapath (top-level ports wr, A, B, opcode, Y).
- Holds a small instruction store and an accumulator.
- After a start pulse, it fetches each instruction and drives A, B, opcode and wr to the datapath for one cycle. It then writes the datapath result Y back into the accumulator and repeats until it hits a halt instruction or the end of the store.
- It replaces hand-sequenced stimulus. It sits between the system/test harness and the datapath.

Parameters:
- DATA_WIDTH, 8: datapath word width; A, B, Y, opcode and the accumulator all use it.
- ADDR_WIDTH, 4: instruction store address width; depth = 2**ADDR_WIDTH.
- HALT_OP, 8'hFF: opcode value that terminates the program. It is never issued to the datapath.

Ports:
- clk  in  1  clock; all logic acts on its rising edge.
- reset  in  1  synchronous, active-high reset.
- prog_we  in  1  instruction store write enable; honoured only in IDLE.
- prog_addr  in  ADDR_WIDTH  instruction store write address.
- prog_data  in  2*DATA_WIDTH  instruction word: [2*DW-1:DW] is the opcode, [DW-1:0] is the immediate.
- start  in  1  begin execution at address 0; honoured only in IDLE.
- acc_init  in  DATA_WIDTH  accumulator value loaded on an accepted start.
- busy  out  1  high in FETCH, ISSUE and WB.
- done  out  1  set when a run completes; cleared by an accepted start or by reset.
- pc  out  ADDR_WIDTH  current instruction address.
- acc  out  DATA_WIDTH  accumulator.
- wr  out  1  datapath write strobe; high only in ISSUE.
- A  out  DATA_WIDTH  datapath operand A, equal to acc at issue.
- B  out  DATA_WIDTH  datapath operand B, equal to the instruction immediate.
- opcode  out  DATA_WIDTH  datapath opcode.
- Y  in  DATA_WIDTH  datapath result; valid in the WB cycle (datapath latency is 1 cycle from wr).

Behaviour:
- Reset:
  - state=IDLE.
  - busy, done, wr = 0.
  - pc, acc, A, B, opcode = 0.
  - Instruction store contents are NOT cleared.
  - Reset in any state aborts the run immediately; no writeback occurs.
- State machine: IDLE, FETCH, ISSUE, WB. All outputs are registered or decoded from the state register only.
- IDLE:
  - If prog_we=1, store[prog_addr] <= prog_data.
  - If start=1: pc<=0, acc<=acc_init, done<=0, go to FETCH.
  - If start and prog_we are asserted in the same cycle, both take effect. A write to address 0 is visible to the following FETCH.
- FETCH (1 cycle): read store[pc].
  - If the opcode field == HALT_OP: done<=1, go to IDLE. wr is not asserted.
  - Otherwise: A<=acc, B<=imm, opcode<=opcode field, go to ISSUE.
- ISSUE (1 cycle): wr=1. A, B and opcode are stable for the whole cycle. Go to WB.
- WB (1 cycle): acc<=Y.
  - If pc == 2**ADDR_WIDTH-1: done<=1, pc holds, go to IDLE. There is no wrap to address 0.
  - Otherwise: pc<=pc+1, go to FETCH.
- Timing:
  - 3 cycles per executed instruction; the halt costs 1 cycle.
  - A run of N instructions followed by a halt returns to IDLE 3N+1 cycles after the start edge.
- Held values:
  - A, B and opcode keep their last issued values outside ISSUE.
  - acc and pc keep their final values in IDLE until the next start.
- Ignored inputs:
  - start is ignored while busy; the run is not restarted.
  - prog_we is ignored while busy; the store is unchanged.
- Width rules: no arithmetic on data beyond the pc increment. acc takes Y verbatim (the datapath owns overflow).

Test Plan:
1. Load [0]={00,04}, [1]={02,01}, [2]={FF,00}; acc_init=8; pulse start. Required response:
   - wr pulses twice, with A=8,B=4,op=00, then A=12,B=1,op=02.
   - acc=12, then acc=11.
   - done=1 and busy=0 exactly 7 cycles after the start edge; pc=2.
2. Halt at address 0, acc_init=5, start. Required response:
   - wr is never asserted.
   - done=1 two edges after start; acc=5; busy high for 1 cycle.
3. Fill all 16 entries with {00,01} (no halt), acc_init=0, start. Required response:
   - 16 wr pulses; acc=16.
   - pc=15 and done=1 after 48 cycles; no wrap.
4. In a program from test 1, assert start and prog_we to [1] during ISSUE of instr 0. Required response:
   - No restart; the store is unchanged; results match test 1.
5. Assert reset during WB of instr 0 of the test-1 program. Required response:
   - Next cycle: IDLE, all outputs 0, acc=0.
   - Re-start runs test 1 correctly, which proves the store was retained.
6. In IDLE, assert prog_we to [0]={FF,00} and start in the same cycle. Required response: the run halts immediately, done=1, and wr is never asserted.
